// File: rtl/timebase_controller.sv
// timebase_controller
//   Run-time programmable timebase. A half-period counter running off the
//   system clock toggles clk_out every `half` cycles, giving a 50% duty square
//   wave of period 2*half, plus a one-cycle tick on each rising edge of it.
//   The half-period can be retuned through a valid/ready port while running.
//   A new value takes effect only on a toggle edge, so clk_out never glitches.
//
//   Optional feature macro: TIMEBASE_TICK_COUNT_EN adds the tick_count output,
//   which counts ticks since the last start.
//
// Ports
//   clk_100MHZ  in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   begin running when idle
//   stop        in   halt and return to idle (wins over start)
//   cfg_valid   in   configuration request
//   cfg_half    in   requested half-period in clk cycles (must be >= 2)
//   cfg_ready   out  request accepted when cfg_valid && cfg_ready
//   cfg_err     out  one-cycle pulse when an accepted request is rejected
//   running     out  high in RUN
//   clk_out     out  divided square wave
//   tick        out  one-cycle pulse in the first cycle clk_out reads 1
//   tick_count  out  ticks since start (TIMEBASE_TICK_COUNT_EN only)
//
// state | meaning
// IDLE  | counter and clk_out held at 0, waiting for start
// RUN   | counter advancing, clk_out toggling every half cycles

module timebase_controller #(
    parameter int DIV_W        = 27,
    parameter int DEFAULT_HALF = 50_000_000,
    parameter int CNT_W        = 32
) (
    input  logic             clk_100MHZ,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             running,
    output logic             clk_out,
`ifdef TIMEBASE_TICK_COUNT_EN
    output logic             tick,
    output logic [CNT_W-1:0] tick_count
`else
    output logic             tick
`endif
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic [DIV_W-1:0] pend_half_q, pend_half_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             cfg_accept, cfg_bad, cfg_good;

    assign cfg_accept = cfg_valid && !pend_q;
    assign cfg_bad    = cfg_accept && (cfg_half < DIV_W'(2));
    assign cfg_good   = cfg_accept && !cfg_bad;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clk_d       = clk_q;
        tick_d      = 1'b0;
        half_d      = half_q;
        pend_d      = pend_q;
        pend_half_d = pend_half_q;
        err_d       = cfg_bad;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (cfg_good) half_d = cfg_half;
                if (start && !stop) state_d = RUN;
            end
            RUN: begin
                if (stop) begin
                    // Any toggle due on this edge is dropped; a pending or
                    // freshly accepted value lands here instead.
                    state_d = IDLE;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                    if (pend_q) begin
                        half_d = pend_half_q;
                        pend_d = 1'b0;
                    end else if (cfg_good) begin
                        half_d = cfg_half;
                    end
                end else begin
                    if (cnt_q == half_q - DIV_W'(1)) begin
                        cnt_d  = '0;
                        clk_d  = ~clk_q;
                        tick_d = ~clk_q;
                        if (pend_q) begin
                            half_d = pend_half_q;
                            pend_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                    // Retuning mid-run waits for the next toggle edge so the
                    // current half-period is never shortened or stretched.
                    if (cfg_good) begin
                        pend_d      = 1'b1;
                        pend_half_d = cfg_half;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHZ) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            half_q      <= DIV_W'(DEFAULT_HALF);
            pend_half_q <= '0;
            pend_q      <= 1'b0;
            clk_q       <= 1'b0;
            tick_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            pend_half_q <= pend_half_d;
            pend_q      <= pend_d;
            clk_q       <= clk_d;
            tick_q      <= tick_d;
            err_q       <= err_d;
        end
    end

`ifdef TIMEBASE_TICK_COUNT_EN
    logic [CNT_W-1:0] tcnt_q;

    always_ff @(posedge clk_100MHZ) begin
        if (rst) begin
            tcnt_q <= '0;
        end else if (state_q == IDLE && state_d == RUN) begin
            tcnt_q <= '0;
        end else if (tick_q) begin
            tcnt_q <= tcnt_q + CNT_W'(1);
        end
    end

    assign tick_count = tcnt_q;
`endif

    assign cfg_ready = !pend_q;
    assign cfg_err   = err_q;
    assign running   = (state_q == RUN);
    assign clk_out   = clk_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_timebase_controller.sv
module tb_timebase_controller;

    localparam int DIV_W = 8;
    localparam int DEF   = 4;
    localparam int CNT_W = 4;

    logic             clk_100MHZ = 1'b0;
    logic             rst = 1'b0, start = 1'b0, stop = 1'b0, cfg_valid = 1'b0;
    logic [DIV_W-1:0] cfg_half = '0;
    logic             cfg_ready, cfg_err, running, clk_out, tick;
`ifdef TIMEBASE_TICK_COUNT_EN
    logic [CNT_W-1:0] tick_count;
`endif

    timebase_controller #(.DIV_W(DIV_W), .DEFAULT_HALF(DEF), .CNT_W(CNT_W)) dut (
        .clk_100MHZ(clk_100MHZ), .rst(rst), .start(start), .stop(stop),
        .cfg_valid(cfg_valid), .cfg_half(cfg_half), .cfg_ready(cfg_ready),
        .cfg_err(cfg_err), .running(running), .clk_out(clk_out),
`ifdef TIMEBASE_TICK_COUNT_EN
        .tick(tick), .tick_count(tick_count)
`else
        .tick(tick)
`endif
    );

    always #5 clk_100MHZ = ~clk_100MHZ;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: elapsed cycles in the current half-period, output
    // level, active half, and a one-deep queue of deferred configurations.
    bit m_run, m_lvl, m_tick, m_err;
    int m_el, m_half, m_tc;
    int m_pend[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit accept, bad, good, old_tick;
        if (rst) begin
            m_run = 0; m_lvl = 0; m_tick = 0; m_err = 0;
            m_el = 0; m_half = DEF; m_tc = 0; m_pend.delete();
            return;
        end
        accept   = cfg_valid && (m_pend.size() == 0);
        bad      = accept && (int'(cfg_half) < 2);
        good     = accept && !bad;
        old_tick = m_tick;
        m_err    = bad;
        m_tick   = 0;
        if (!m_run) begin
            m_lvl = 0; m_el = 0;
            if (good) m_half = int'(cfg_half);
            if (start && !stop) begin
                m_run = 1; m_tc = 0;
            end
        end else begin
            if (old_tick) m_tc = (m_tc + 1) % (1 << CNT_W);
            if (stop) begin
                m_run = 0; m_lvl = 0; m_el = 0;
                if (m_pend.size() != 0) m_half = m_pend.pop_front();
                else if (good) m_half = int'(cfg_half);
            end else begin
                m_el++;
                if (m_el == m_half) begin
                    m_el   = 0;
                    m_lvl  = !m_lvl;
                    m_tick = m_lvl;
                    if (m_pend.size() != 0) m_half = m_pend.pop_front();
                end
                if (good) m_pend.push_back(int'(cfg_half));
            end
        end
    endtask

    task automatic compare_all();
        check("running", 32'(running), 32'(m_run));
        check("clk_out", 32'(clk_out), 32'(m_lvl));
        check("tick", 32'(tick), 32'(m_tick));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
        check("cfg_ready", 32'(cfg_ready), 32'(m_pend.size() == 0));
`ifdef TIMEBASE_TICK_COUNT_EN
        check("tick_count", 32'(tick_count), 32'(m_tc));
`endif
    endtask

    // Called just after a falling edge: apply inputs, clock once, check.
    task automatic step(input bit r, input bit s, input bit p, input bit v, input int h);
        rst = r; start = s; stop = p; cfg_valid = v; cfg_half = DIV_W'(h);
        @(posedge clk_100MHZ);
        model_step();
        @(negedge clk_100MHZ);
        compare_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Cycles until clk_out reads 1, bounded; an expired bound fails the check.
    task automatic wait_rise(input string tag, input int exp);
        int k;
        k = 0;
        for (int i = 0; i < 64; i++) begin
            step(0, 0, 0, 0, 0);
            k++;
            if (clk_out) break;
        end
        check(tag, 32'(k), 32'(exp));
    endtask

    initial begin
        int highs;
        @(negedge clk_100MHZ);

        // Reset values
        step(1, 1, 0, 1, 7);
        check("rst_running", 32'(running), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_clk_out", 32'(clk_out), 32'd0);

        // half=3 in idle, start, first rise 3 cycles later, 50% duty
        step(0, 0, 0, 1, 3);
        step(0, 1, 0, 0, 0);
        check("start_running", 32'(running), 32'd1);
        wait_rise("first_rise_h3", 3);
        check("first_tick", 32'(tick), 32'd1);
        highs = 0;
        for (int i = 0; i < 24; i++) begin
            step(0, 0, 0, 0, 0);
            if (clk_out) highs++;
        end
        check("duty_4_periods", 32'(highs), 32'd12);

        // Retune mid-half-period to 5
        step(0, 0, 0, 1, 5);
        check("pending_not_ready", 32'(cfg_ready), 32'd0);
        idle_steps(30);

        // Rejected configs
        step(0, 0, 0, 1, 1);
        check("err_half1", 32'(cfg_err), 32'd1);
        step(0, 0, 0, 1, 0);
        check("err_half0", 32'(cfg_err), 32'd1);
        idle_steps(12);

        // stop, then start+stop together from idle
        step(0, 0, 1, 0, 0);
        check("stopped", 32'(running), 32'd0);
        step(0, 1, 1, 0, 0);
        check("start_stop_idle", 32'(running), 32'd0);

        // stop on the cycle just before the first toggle (half=5)
        step(0, 1, 0, 0, 0);
        idle_steps(4);
        step(0, 0, 1, 0, 0);
        check("stop_supp_clk", 32'(clk_out), 32'd0);
        check("stop_supp_tick", 32'(tick), 32'd0);

        // rst mid-run with pending config, then default half
        step(0, 1, 0, 0, 0);
        idle_steps(2);
        step(0, 0, 0, 1, 9);
        step(1, 0, 0, 0, 0);
        check("rst_mid_ready", 32'(cfg_ready), 32'd1);
        step(0, 1, 0, 0, 0);
        wait_rise("first_rise_default", DEF);

        // half=2, 10 full periods
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 2);
        step(0, 1, 0, 0, 0);
        idle_steps(39);
`ifdef TIMEBASE_TICK_COUNT_EN
        check("tc_10", 32'(tick_count), 32'd10);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        check("tc_restart", 32'(tick_count), 32'd0);
        idle_steps(67);
        check("tc_wrap17", 32'(tick_count), 32'd1);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) == 0, $urandom_range(19) == 0,
                 $urandom_range(39) == 0, $urandom_range(4) == 0,
                 ($urandom_range(7) == 0) ? int'($urandom_range(255)) : int'($urandom_range(7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
